// File: rtl/task_scheduler_param_pkg.sv
// Shared types and field-layout helpers for the task scheduler.
package task_scheduler_param_pkg;

  typedef enum logic [1:0] {
    FENCE_NO  = 2'd0,
    FENCE_ACQ = 2'd1,
    FENCE_REL = 2'd2
  } fence_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_ISSUE,
    ST_DRAIN
  } state_e;

  localparam int unsigned FENCE_W = 2;

  // Control frame layout, LSB first: fence | ifn | active | r0_vect | r0
  function automatic int unsigned ifn_lsb();
    return FENCE_W;
  endfunction

  function automatic int unsigned act_lsb(input int unsigned ifn_w);
    return FENCE_W + ifn_w;
  endfunction

  function automatic int unsigned r0v_lsb(input int unsigned ifn_w, input int unsigned nc);
    return FENCE_W + ifn_w + nc;
  endfunction

  function automatic int unsigned r0_lsb(input int unsigned ifn_w, input int unsigned nc);
    return FENCE_W + ifn_w + 2 * nc;
  endfunction

  function automatic int unsigned min_frame_w(input int unsigned ifn_w, input int unsigned nc,
                                              input int unsigned r0_w);
    return FENCE_W + ifn_w + 2 * nc + nc * r0_w;
  endfunction

  // Encoding 3 is reserved and behaves as NO.
  function automatic fence_e decode_fence(input logic [1:0] f);
    case (f)
      2'd1:    return FENCE_ACQ;
      2'd2:    return FENCE_REL;
      default: return FENCE_NO;
    endcase
  endfunction

endpackage

// File: rtl/task_scheduler_param_if.sv
// Scheduler-to-core-array handshake bundle.
interface task_scheduler_param_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned FRAME_W   = 128,
  parameter int unsigned R0_W      = 8
);
  logic [NUM_CORES-1:0]      Ready;
  logic [NUM_CORES-1:0]      Start;
  logic [FRAME_W-1:0]        Insn_Data;
  logic [NUM_CORES-1:0]      Init_R0_Vect;
  logic [NUM_CORES*R0_W-1:0] Init_R0;

  modport master (input Ready, output Start, Insn_Data, Init_R0_Vect, Init_R0);
  modport slave  (output Ready, input Start, Insn_Data, Init_R0_Vect, Init_R0);
endinterface

// File: rtl/task_scheduler_param_tm_ram.sv
// Task memory: synchronous write, asynchronous read; a same-cycle write is
// only visible after the edge, so a colliding read returns the old frame.
module task_scheduler_param_tm_ram #(
  parameter  int unsigned TM_DEPTH = 64,
  parameter  int unsigned FRAME_W  = 128,
  localparam int unsigned AW       = $clog2(TM_DEPTH)
) (
  input  logic               clk,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [FRAME_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [FRAME_W-1:0] o_rd_data
);
  logic [FRAME_W-1:0] r_mem [TM_DEPTH];

  // Frame write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/task_scheduler_param.sv
// Task scheduler: walks task memory, dispatches control frames and issues
// instruction frames to the core array with fence ordering.
module task_scheduler_param
  import task_scheduler_param_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 4,
  parameter  int unsigned TM_DEPTH  = 64,
  parameter  int unsigned FRAME_W   = 128,
  parameter  int unsigned IFN_W     = 4,
  parameter  int unsigned R0_W      = 8,
  localparam int unsigned AW        = $clog2(TM_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               env_tm_wr_en,
  input  logic [AW-1:0]      env_tm_wr_addr,
  input  logic [FRAME_W-1:0] env_tm_wr_data,
  input  logic               env_run,
  input  logic [AW-1:0]      env_start_addr,
  input  logic               env_abort,
  output logic               Busy,
  output logic               Done,
  task_scheduler_param_if.master core
);
  localparam int unsigned IFN_LSB = ifn_lsb();
  localparam int unsigned ACT_LSB = act_lsb(IFN_W);
  localparam int unsigned R0V_LSB = r0v_lsb(IFN_W, NUM_CORES);
  localparam int unsigned R0_LSB  = r0_lsb(IFN_W, NUM_CORES);

  if (FRAME_W < min_frame_w(IFN_W, NUM_CORES, R0_W)) begin : g_frame_w_check
    $error("FRAME_W too small for control frame fields");
  end

  state_e                    r_state, w_state_nxt;
  logic [AW-1:0]             r_ptr, w_ptr_nxt;
  fence_e                    r_prev_fence, w_prev_fence_nxt;
  logic [IFN_W-1:0]          r_cnt, w_cnt_nxt;
  logic [NUM_CORES-1:0]      r_active, w_active_nxt;
  logic [NUM_CORES-1:0]      r_start, w_start_nxt;
  logic [FRAME_W-1:0]        r_insn, w_insn_nxt;
  logic [NUM_CORES-1:0]      r_r0v, w_r0v_nxt;
  logic [NUM_CORES*R0_W-1:0] r_r0, w_r0_nxt;
  logic                      r_busy, r_done, w_done_nxt;

  logic [FRAME_W-1:0]        w_frame;
  fence_e                    w_fence;
  logic [IFN_W-1:0]          w_ifn;
  logic [NUM_CORES-1:0]      w_act;
  logic                      w_halt, w_all_ready, w_dispatch_ok, w_issue_ok;

  task_scheduler_param_tm_ram #(
    .TM_DEPTH (TM_DEPTH),
    .FRAME_W  (FRAME_W)
  ) u_tm_ram (
    .clk       (clk),
    .i_wr_en   (env_tm_wr_en),
    .i_wr_addr (env_tm_wr_addr),
    .i_wr_data (env_tm_wr_data),
    .i_rd_addr (r_ptr),
    .o_rd_data (w_frame)
  );

  assign w_fence     = decode_fence(w_frame[1:0]);
  assign w_ifn       = w_frame[IFN_LSB +: IFN_W];
  assign w_act       = w_frame[ACT_LSB +: NUM_CORES];
  assign w_halt      = (w_ifn == '0) && (w_act == '0);
  assign w_all_ready = &core.Ready;
  assign w_issue_ok  = ((~core.Ready & r_active) == '0);
  // A fenced frame (acquire behind, or release here) needs the whole array idle.
  assign w_dispatch_ok = ((r_prev_fence == FENCE_ACQ) || (w_fence == FENCE_REL))
                         ? w_all_ready
                         : ((~core.Ready & w_act) == '0);

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_prev_fence_nxt = r_prev_fence;
    w_cnt_nxt        = r_cnt;
    w_active_nxt     = r_active;
    w_start_nxt      = '0;
    w_insn_nxt       = r_insn;
    w_r0v_nxt        = r_r0v;
    w_r0_nxt         = r_r0;
    w_done_nxt       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (env_run) begin
          w_ptr_nxt   = env_start_addr;
          w_state_nxt = ST_CTRL;
        end
      end
      ST_CTRL: begin
        if (w_halt) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_dispatch_ok) begin
          w_active_nxt     = w_act;
          w_prev_fence_nxt = w_fence;
          w_cnt_nxt        = w_ifn;
          w_r0v_nxt        = w_frame[R0V_LSB +: NUM_CORES];
          w_r0_nxt         = w_frame[R0_LSB +: NUM_CORES*R0_W];
          w_ptr_nxt        = r_ptr + AW'(1);
          if (w_ifn != '0) w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_issue_ok) begin
          w_start_nxt = r_active;
          w_insn_nxt  = w_frame;
          w_ptr_nxt   = r_ptr + AW'(1);
          w_cnt_nxt   = r_cnt - IFN_W'(1);
          if (r_cnt == IFN_W'(1)) w_state_nxt = ST_CTRL;
        end
      end
      ST_DRAIN: begin
        if (w_all_ready) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides whatever the state decode chose; R0 and instruction outputs hold.
    if (env_abort && (r_state != ST_IDLE)) begin
      w_state_nxt      = ST_IDLE;
      w_start_nxt      = '0;
      w_prev_fence_nxt = FENCE_NO;
      w_done_nxt       = 1'b0;
      w_insn_nxt       = r_insn;
      w_r0v_nxt        = r_r0v;
      w_r0_nxt         = r_r0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= '0;
      r_prev_fence <= FENCE_NO;
      r_cnt        <= '0;
      r_active     <= '0;
      r_start      <= '0;
      r_insn       <= '0;
      r_r0v        <= '0;
      r_r0         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_prev_fence <= w_prev_fence_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active     <= w_active_nxt;
      r_start      <= w_start_nxt;
      r_insn       <= w_insn_nxt;
      r_r0v        <= w_r0v_nxt;
      r_r0         <= w_r0_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= w_done_nxt;
    end
  end

  assign Busy              = r_busy;
  assign Done              = r_done;
  assign core.Start        = r_start;
  assign core.Insn_Data    = r_insn;
  assign core.Init_R0_Vect = r_r0v;
  assign core.Init_R0      = r_r0;
endmodule

// File: tb/tb_task_scheduler_param.sv
// Directed and randomized bench for task_scheduler_param.
module tb_task_scheduler_param;
  localparam int unsigned NC = 4;
  localparam int unsigned TD = 64;
  localparam int unsigned FW = 128;
  localparam int unsigned IW = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          env_tm_wr_en;
  logic [AW-1:0] env_tm_wr_addr;
  logic [FW-1:0] env_tm_wr_data;
  logic          env_run;
  logic [AW-1:0] env_start_addr;
  logic          env_abort;
  logic          Busy, Done;

  task_scheduler_param_if #(.NUM_CORES(NC), .FRAME_W(FW), .R0_W(RW)) u_if ();

  task_scheduler_param #(
    .NUM_CORES (NC),
    .TM_DEPTH  (TD),
    .FRAME_W   (FW),
    .IFN_W     (IW),
    .R0_W      (RW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .env_tm_wr_en   (env_tm_wr_en),
    .env_tm_wr_addr (env_tm_wr_addr),
    .env_tm_wr_data (env_tm_wr_data),
    .env_run        (env_run),
    .env_start_addr (env_start_addr),
    .env_abort      (env_abort),
    .Busy           (Busy),
    .Done           (Done),
    .core           (u_if)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [FW-1:0] mem_m [TD];

  typedef struct packed {
    logic [NC-1:0]    act;
    logic [FW-1:0]    data;
    logic [NC-1:0]    r0v;
    logic [NC*RW-1:0] r0;
  } issue_t;
  issue_t exp_q[$];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mk_ctrl(input int unsigned fence, input int unsigned ifn,
                                            input logic [NC-1:0] act, input logic [NC-1:0] r0v,
                                            input logic [NC*RW-1:0] r0);
    logic [FW-1:0] f;
    f = FW'(fence & 3);
    f = f | (FW'(ifn & 15) << 2);
    f = f | (FW'(act) << 6);
    f = f | (FW'(r0v) << 10);
    f = f | (FW'(r0) << 14);
    return f;
  endfunction

  function automatic logic [FW-1:0] rnd_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wr(input logic [AW-1:0] addr, input logic [FW-1:0] data);
    env_tm_wr_en   = 1'b1;
    env_tm_wr_addr = addr;
    env_tm_wr_data = data;
    mem_m[addr]    = data;
    tick();
    env_tm_wr_en   = 1'b0;
  endtask

  task automatic pulse_run(input logic [AW-1:0] addr);
    env_run        = 1'b1;
    env_start_addr = addr;
    tick();
    env_run        = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (Done) seen = 1'b1;
    end
    chk(tag, FW'(seen), FW'(1'b1));
  endtask

  // Walk the program the way the environment describes it and list every visible issue.
  task automatic build_expected(input logic [AW-1:0] start);
    logic [AW-1:0]    p;
    logic [FW-1:0]    f;
    logic [IW-1:0]    ifn;
    logic [NC-1:0]    act, r0v;
    logic [NC*RW-1:0] r0;
    p = start;
    exp_q.delete();
    for (int t = 0; t < 40; t++) begin
      f   = mem_m[p];
      ifn = f[5:2];
      act = f[9:6];
      r0v = f[13:10];
      r0  = f[45:14];
      if (ifn == 0 && act == 0) break;
      p = p + 6'd1;
      for (int k = 0; k < int'(ifn); k++) begin
        if (act != 0) exp_q.push_back('{act, mem_m[p], r0v, r0});
        p = p + 6'd1;
      end
    end
  endtask

  task automatic gen_prog(input logic [AW-1:0] start);
    logic [AW-1:0] p;
    logic [FW-1:0] c, f;
    int unsigned   ifn;
    p = start;
    for (int t = 0; t < int'($urandom_range(1, 4)); t++) begin
      ifn = $urandom_range(0, 3);
      c = mk_ctrl($urandom_range(0, 3), ifn, 4'($urandom_range(1, 15)), 4'($urandom),
                  32'($urandom));
      f = rnd_frame();
      f[45:0] = c[45:0];
      wr(p, f);
      p = p + 6'd1;
      for (int k = 0; k < int'(ifn); k++) begin
        wr(p, rnd_frame());
        p = p + 6'd1;
      end
    end
    c = mk_ctrl($urandom_range(0, 3), 0, 4'b0000, 4'($urandom), 32'($urandom));
    wr(p, c);
  endtask

  task automatic run_checked(input logic [AW-1:0] start, input bit rnd_ready);
    issue_t        e;
    logic [NC-1:0] applied, r;
    logic          done_seen;
    build_expected(start);
    pulse_run(start);
    done_seen = 1'b0;
    for (int c = 0; c < 600 && !done_seen; c++) begin
      applied = u_if.Ready;
      tick();
      if (u_if.Start != '0) begin
        if (exp_q.size() == 0) begin
          chk("extra_start", FW'(u_if.Start), FW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("start_mask", FW'(u_if.Start), FW'(e.act));
          chk("insn_data", u_if.Insn_Data, e.data);
          chk("r0_vect", FW'(u_if.Init_R0_Vect), FW'(e.r0v));
          chk("r0_value", FW'(u_if.Init_R0), FW'(e.r0));
          chk("issue_ready", FW'(~applied & u_if.Start), FW'(0));
        end
      end
      if (Done) begin
        done_seen = 1'b1;
        chk("drain_ready", FW'(applied), FW'(4'b1111));
      end
      if (rnd_ready) begin
        for (int b = 0; b < int'(NC); b++) r[b] = ($urandom_range(0, 3) != 0);
        u_if.Ready = r;
      end
    end
    u_if.Ready = '1;
    chk("run_done", FW'(done_seen), FW'(1'b1));
    chk("queue_empty", FW'(exp_q.size()), FW'(0));
    chk("busy_after", FW'(Busy), FW'(1'b0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, FW'(u_if.Start), FW'(0));
    chk({tag, "_insn"}, u_if.Insn_Data, FW'(0));
    chk({tag, "_r0v"}, FW'(u_if.Init_R0_Vect), FW'(0));
    chk({tag, "_r0"}, FW'(u_if.Init_R0), FW'(0));
    chk({tag, "_busy"}, FW'(Busy), FW'(0));
    chk({tag, "_done"}, FW'(Done), FW'(0));
  endtask

  logic [FW-1:0] F1, F2, F3, F4, F5, F6, F7, F8;
  logic [AW-1:0] sa;

  initial begin
    reset = 1'b0; env_tm_wr_en = 1'b0; env_tm_wr_addr = '0; env_tm_wr_data = '0;
    env_run = 1'b0; env_start_addr = '0; env_abort = 1'b0; u_if.Ready = '1;
    F1 = rnd_frame(); F2 = rnd_frame(); F3 = rnd_frame(); F4 = rnd_frame();
    F5 = rnd_frame(); F6 = rnd_frame(); F7 = rnd_frame(); F8 = rnd_frame();
    tick(); tick();
    chk_all_zero("reset");
    @(negedge clk); reset = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Basic dispatch and issue, with Done held off until all cores are idle.
    wr(0, mk_ctrl(0, 2, 4'b0011, 4'b0001, 32'h5A));
    wr(1, F1); wr(2, F2); wr(3, '0);
    pulse_run(0);
    chk("t1_busy", FW'(Busy), FW'(1'b1));
    tick();
    chk("t1_r0v", FW'(u_if.Init_R0_Vect), FW'(4'b0001));
    chk("t1_r0", FW'(u_if.Init_R0), FW'(32'h5A));
    chk("t1_nostart", FW'(u_if.Start), FW'(0));
    tick();
    chk("t1_start1", FW'(u_if.Start), FW'(4'b0011));
    chk("t1_insn1", u_if.Insn_Data, F1);
    tick();
    chk("t1_start2", FW'(u_if.Start), FW'(4'b0011));
    chk("t1_insn2", u_if.Insn_Data, F2);
    u_if.Ready = 4'b0111;
    tick();
    chk("t1_start_low", FW'(u_if.Start), FW'(0));
    tick();
    chk("t1_drain_wait", FW'(Done), FW'(0));
    chk("t1_drain_busy", FW'(Busy), FW'(1));
    u_if.Ready = 4'b1111;
    tick();
    chk("t1_done", FW'(Done), FW'(1));
    chk("t1_busy_off", FW'(Busy), FW'(0));
    tick();
    chk("t1_done_pulse", FW'(Done), FW'(0));

    // REL fence waits for the whole array.
    wr(8, mk_ctrl(2, 1, 4'b0001, 4'b0001, 32'h77));
    wr(9, F3); wr(10, '0);
    u_if.Ready = 4'b1011;
    pulse_run(8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_start", FW'(u_if.Start), FW'(0));
      chk("t2_hold_r0", FW'(u_if.Init_R0), FW'(32'h5A));
    end
    u_if.Ready = 4'b1111;
    tick();
    chk("t2_disp_start", FW'(u_if.Start), FW'(0));
    chk("t2_disp_r0", FW'(u_if.Init_R0), FW'(32'h77));
    tick();
    chk("t2_start", FW'(u_if.Start), FW'(4'b0001));
    chk("t2_insn", u_if.Insn_Data, F3);
    wait_done("t2_done");

    // ACQ followed by a core-0 frame: core 3 busy blocks the second frame.
    wr(16, mk_ctrl(1, 1, 4'b0001, 4'b0000, 32'h0));
    wr(17, F4);
    wr(18, mk_ctrl(0, 1, 4'b0001, 4'b0001, 32'h33));
    wr(19, F5); wr(20, '0);
    u_if.Ready = 4'b0111;
    pulse_run(16);
    tick(); tick();
    chk("t3_start1", FW'(u_if.Start), FW'(4'b0001));
    chk("t3_insn1", u_if.Insn_Data, F4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_acq_hold", FW'(u_if.Start), FW'(0));
    end
    u_if.Ready = 4'b1111;
    tick();
    chk("t3_r0", FW'(u_if.Init_R0), FW'(32'h33));
    tick();
    chk("t3_start2", FW'(u_if.Start), FW'(4'b0001));
    chk("t3_insn2", u_if.Insn_Data, F5);
    wait_done("t3_done");

    // Pointer wraps from the last frame to address 0.
    wr(63, mk_ctrl(0, 2, 4'b1111, 4'b1111, 32'hDDCCBBAA));
    wr(0, F6); wr(1, F7); wr(2, '0);
    pulse_run(63);
    tick();
    chk("t4_r0", FW'(u_if.Init_R0), FW'(32'hDDCCBBAA));
    tick();
    chk("t4_insn1", u_if.Insn_Data, F6);
    tick();
    chk("t4_insn2", u_if.Insn_Data, F7);
    chk("t4_start2", FW'(u_if.Start), FW'(4'b1111));
    wait_done("t4_done");

    // Abort mid-issue, then a normal rerun.
    wr(24, mk_ctrl(0, 3, 4'b0010, 4'b0010, 32'h0000C300));
    wr(25, F8); wr(26, rnd_frame()); wr(27, rnd_frame()); wr(28, '0);
    pulse_run(24);
    tick(); tick();
    chk("t5_start", FW'(u_if.Start), FW'(4'b0010));
    env_abort = 1'b1;
    tick();
    env_abort = 1'b0;
    chk("t5_busy", FW'(Busy), FW'(0));
    chk("t5_start_clr", FW'(u_if.Start), FW'(0));
    chk("t5_insn_hold", u_if.Insn_Data, F8);
    chk("t5_r0_hold", FW'(u_if.Init_R0), FW'(32'h0000C300));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_quiet", FW'({u_if.Start, Done, Busy}), FW'(0));
    end
    run_checked(24, 1'b0);

    // Asynchronous reset in the middle of an issue burst.
    pulse_run(24);
    tick(); tick();
    chk("t6_start", FW'(u_if.Start), FW'(4'b0010));
    #2 reset = 1'b0;
    #1 chk_all_zero("t6_async");
    @(negedge clk); reset = 1'b1;
    tick();
    chk("t6_idle", FW'({u_if.Start, Busy}), FW'(0));
    run_checked(24, 1'b1);

    // Random programs at random start addresses with random core stalls.
    for (int r = 0; r < 8; r++) begin
      sa = AW'($urandom_range(0, TD - 1));
      gen_prog(sa);
      run_checked(sa, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
